// File: rtl/pairing_host_ctrl.sv
// Host-side controller for the pairing core's external memory port: loads operands, pulses run, unloads results.
// Optional watchdog on the core wait states is enabled by defining PAIRING_HOST_WDOG_EN.
module pairing_host_ctrl #(
  parameter int DATA_W = 304,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
`ifdef PAIRING_HOST_WDOG_EN
  ,
  parameter logic [23:0] WDOG_CYC = 24'hFFFFFF
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        n_func,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              core_extin_en,
  output logic [ADDR_W-1:0] core_extin_addr,
  output logic [DATA_W-1:0] core_extin_data,
  output logic              core_run,
  output logic [3:0]        core_n_func,
  input  logic              core_busy,
  output logic [ADDR_W-1:0] core_extout_addr,
  input  logic [DATA_W-1:0] core_extout_data,
  output logic              done,
  output logic              err,
  output logic              idle
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_UNLOAD  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int IF_W  = $clog2(RD_LAT + 1);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        func_reg;
  logic [ADDR_W-1:0] ld_base_reg, ld_len_reg, rd_base_reg, rd_len_reg;
  logic [ADDR_W-1:0] ld_cnt_reg, iss_cnt_reg, out_cnt_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic              err_reg;
  logic [RD_LAT-1:0] issue_sr_reg, issue_sr_next;
  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_cnt_reg;
  logic [IF_W-1:0]   in_flight;
  logic              load_fire, issue, push, pop, wdog_hit;

  // Gating with rstn stops any write or run pulse in the very cycle reset is asserted.
  assign s_ready         = rstn && (state_reg == S_LOAD) && !core_busy;
  assign load_fire       = s_ready && s_valid;
  assign core_extin_en   = load_fire;
  assign core_extin_addr = ld_base_reg + ld_cnt_reg;
  assign core_extin_data = load_fire ? s_data : '0;
  assign core_run        = rstn && (state_reg == S_RUN);
  assign core_n_func     = func_reg;
  assign done            = (state_reg == S_DONE);
  assign idle            = (state_reg == S_IDLE);
  assign err             = err_reg;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + IF_W'(issue_sr_reg[i]);
  end

  // Credit check counts words still in the core pipeline so the FIFO can never overflow.
  assign issue = (state_reg == S_UNLOAD) && (iss_cnt_reg != rd_len_reg) &&
                 ((int'(in_flight) + int'(fifo_cnt_reg)) < FIFO_D);
  assign core_extout_addr = issue ? (rd_base_reg + iss_cnt_reg) : addr_hold_reg;

  assign issue_sr_next[0] = issue;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_issue_sr
      assign issue_sr_next[gi] = issue_sr_reg[gi-1];
    end
  endgenerate

  assign push    = issue_sr_reg[RD_LAT-1];
  assign m_valid = (fifo_cnt_reg != '0);
  assign m_data  = m_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign m_last  = m_valid && (out_cnt_reg == rd_len_reg - ADDR_W'(1));
  assign pop     = m_valid && m_ready;

`ifdef PAIRING_HOST_WDOG_EN
  logic [23:0] wdog_reg;
  logic        in_wait;
  assign in_wait  = (state_reg == S_WAIT_HI) || (state_reg == S_WAIT_LO);
  assign wdog_hit = in_wait && (wdog_reg >= WDOG_CYC - 24'd1);
  always_ff @(posedge clk) begin
    if (!rstn)        wdog_reg <= '0;
    else if (in_wait) wdog_reg <= wdog_reg + 24'd1;
    else              wdog_reg <= '0;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = (ld_len != '0) ? S_LOAD : S_RUN;
      S_LOAD:    if (load_fire && (ld_cnt_reg == ld_len_reg - ADDR_W'(1))) state_next = S_RUN;
      S_RUN:     state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (wdog_hit)       state_next = S_DONE;
        else if (core_busy) state_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (wdog_hit)        state_next = S_DONE;
        else if (!core_busy) state_next = (rd_len_reg != '0) ? S_UNLOAD : S_DONE;
      end
      S_UNLOAD:  if (pop && m_last) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      func_reg      <= '0;
      ld_base_reg   <= '0;
      ld_len_reg    <= '0;
      rd_base_reg   <= '0;
      rd_len_reg    <= '0;
      ld_cnt_reg    <= '0;
      iss_cnt_reg   <= '0;
      out_cnt_reg   <= '0;
      addr_hold_reg <= '0;
      err_reg       <= 1'b0;
      issue_sr_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      issue_sr_reg  <= issue_sr_next;
      addr_hold_reg <= core_extout_addr;
      if ((state_reg == S_IDLE) && start) begin
        func_reg    <= n_func;
        ld_base_reg <= ld_base;
        ld_len_reg  <= ld_len;
        rd_base_reg <= rd_base;
        rd_len_reg  <= rd_len;
        ld_cnt_reg  <= '0;
        iss_cnt_reg <= '0;
        out_cnt_reg <= '0;
        err_reg     <= 1'b0;
      end
      if (load_fire) ld_cnt_reg <= ld_cnt_reg + ADDR_W'(1);
      if ((state_reg == S_LOAD) && core_busy) err_reg <= 1'b1;
      if (wdog_hit) err_reg <= 1'b1;
      if (issue) iss_cnt_reg <= iss_cnt_reg + ADDR_W'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        out_cnt_reg <= out_cnt_reg + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= core_extout_data;
  end

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// Randomized bench for pairing_host_ctrl: a core memory model plus a job-level reference of expected writes and results.
module tb_pairing_host_ctrl;
  localparam int DW = 304;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    n_func = '0;
  logic [AW-1:0] ld_base = '0, ld_len = '0, rd_base = '0, rd_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          core_extin_en, core_run, core_busy;
  logic [AW-1:0] core_extin_addr, core_extout_addr;
  logic [DW-1:0] core_extin_data;
  logic [DW-1:0] core_extout_data;
  logic [3:0]    core_n_func;
  logic          done, err, idle;

  always #5 clk = ~clk;

  pairing_host_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .FIFO_D(4)
`ifdef PAIRING_HOST_WDOG_EN
    , .WDOG_CYC(24'd100)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .n_func(n_func),
    .ld_base(ld_base), .ld_len(ld_len), .rd_base(rd_base), .rd_len(rd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
    .core_extin_data(core_extin_data), .core_run(core_run), .core_n_func(core_n_func),
    .core_busy(core_busy), .core_extout_addr(core_extout_addr),
    .core_extout_data(core_extout_data), .done(done), .err(err), .idle(idle)
  );

  // Core model: BRAM written by extin, read with two cycles of latency, busy for busy_len after a run.
  logic [DW-1:0] cmem [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] rd1, rd2;
  int  pre_cnt = 0, busy_cnt = 0, busy_len = 10;
  bit  force_busy = 1'b0;
  assign core_busy = (busy_cnt > 0) || force_busy;
  assign core_extout_data = rd2;

  always @(posedge clk) begin
    if (core_extin_en) cmem[core_extin_addr] <= core_extin_data;
    rd1 <= cmem[core_extout_addr];
    rd2 <= rd1;
    if (core_run) pre_cnt <= 2;
    else if (pre_cnt > 0) begin
      pre_cnt <= pre_cnt - 1;
      if (pre_cnt == 1) busy_cnt <= busy_len;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Observation of everything that crosses the block boundary.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [DW-1:0] out_q[$];
  bit            last_q[$];
  int  run_cnt, done_cnt, viol, wr_first, wr_last, run_cyc, done_cyc;
  logic [3:0] run_func;

  always @(negedge clk) begin
    if (core_extin_en) begin
      wr_addr_q.push_back(core_extin_addr);
      wr_data_q.push_back(core_extin_data);
      if (core_busy) viol++;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
    end
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      last_q.push_back(m_last);
    end
    if (core_run) begin run_cnt++; run_func = core_n_func; run_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  int total = 0, bad = 0;
  bit job_end;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < 10; i++) w = {w[DW-33:0], $urandom()};
    return w;
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); out_q.delete(); last_q.delete();
    run_cnt = 0; done_cnt = 0; viol = 0; wr_first = -1; wr_last = -1; run_cyc = -1; done_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_start(input logic [AW-1:0] lb, ll, rb, rl, input logic [3:0] fn);
    int t = 0;
    while (!idle && t < 200) begin tick(); t++; end
    start = 1'b1; n_func = fn; ld_base = lb; ld_len = ll; rd_base = rb; rd_len = rl;
    tick();
    start = 1'b0; n_func = $urandom(); ld_base = $urandom(); ld_len = $urandom(); rd_base = $urandom(); rd_len = $urandom();
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit bump);
    int t = 0;
    s_valid = 1'b1; s_data = w;
    if (bump) begin
      force_busy = 1'b1;
      repeat (3) tick();
      force_busy = 1'b0;
    end
    while (1) begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 2000) break;
    end
    tick();
    s_valid = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 toggle then hold low for 20 cycles.
  task automatic do_job(input logic [AW-1:0] lb, ll, rb, rl, input logic [3:0] fn,
                        input int blen, input int rmode, input bit gap, input bit bump,
                        input logic exp_err, input bit chk_timing);
    logic [DW-1:0] words[$];
    logic [DW-1:0] exp_out[$];
    logic [AW-1:0] a;
    int nb;
    clear_mon();
    job_end = 1'b0;
    busy_len = blen;
    for (int i = 0; i < int'(ll); i++) begin
      words.push_back(rand_word());
      a = lb + AW'(i);
      ref_mem[a] = words[i];
    end
    for (int k = 0; k < int'(rl); k++) begin
      a = rb + AW'(k);
      exp_out.push_back(ref_mem[a]);
    end
    issue_start(lb, ll, rb, rl, fn);
    fork
      begin
        for (int i = 0; i < int'(ll); i++) begin
          if (gap && ($urandom_range(0, 2) == 0)) tick();
          push_word(words[i], bump && (i == 1));
        end
      end
      begin
        int k = 0, hold = 0;
        while (!job_end && k < 6000) begin
          case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
              if (out_q.size() < 2) m_ready = (k % 2 == 0);
              else if (hold < 20) begin m_ready = 1'b0; hold++; end
              else m_ready = 1'b1;
            end
          endcase
          tick();
          k++;
        end
        m_ready = 1'b0;
      end
      begin
        int t = 0;
        while (done_cnt == 0 && t < 5000) begin tick(); t++; end
        repeat (3) tick();
        job_end = 1'b1;
      end
    join
    $display("job lb=%h ll=%0d rb=%h rl=%0d fn=%h busy=%0d rmode=%0d writes=%0d outs=%0d done=%0d err=%0b",
             lb, ll, rb, rl, fn, blen, rmode, wr_addr_q.size(), out_q.size(), done_cnt, err);
    check("wr_cnt", DW'(wr_addr_q.size()), DW'(ll));
    nb = 0;
    for (int i = 0; i < wr_addr_q.size() && i < int'(ll); i++) begin
      a = lb + AW'(i);
      if (wr_addr_q[i] !== a || wr_data_q[i] !== words[i]) nb++;
    end
    check("wr_seq", DW'(nb), '0);
    check("run_cnt", DW'(run_cnt), DW'(1));
    check("run_func", DW'(run_func), DW'(fn));
    check("out_cnt", DW'(out_q.size()), DW'(rl));
    nb = 0;
    for (int k = 0; k < out_q.size() && k < int'(rl); k++)
      if (out_q[k] !== exp_out[k] || last_q[k] !== (k == int'(rl) - 1)) nb++;
    check("out_seq", DW'(nb), '0);
    check("done_cnt", DW'(done_cnt), DW'(1));
    check("err", DW'(err), DW'(exp_err));
    check("busy_wr", DW'(viol), '0);
    check("idle_after", DW'(idle), DW'(1));
    if (chk_timing) begin
      check("wr_burst", DW'(wr_last - wr_first), DW'(2));
      check("run_after_wr", DW'(run_cyc), DW'(wr_last + 1));
    end
  endtask

  initial begin
    logic [DW-1:0] w0, w1;
    for (int i = 0; i < 1024; i++) begin
      cmem[i] = rand_word();
      ref_mem[i] = cmem[i];
    end
    clear_mon();
    repeat (3) tick();
    rstn = 1'b1;
    check("rst_idle", DW'(idle), DW'(1));
    check("rst_sready", DW'(s_ready), '0);
    check("rst_mvalid", DW'(m_valid), '0);
    check("rst_done", DW'(done), '0);
    check("rst_err", DW'(err), '0);
    check("rst_run", DW'(core_run), '0);
    check("rst_extaddr", DW'(core_extout_addr), '0);
    check("rst_func", DW'(core_n_func), '0);

    do_job(10'h010, 10'd3, 10'h010, 10'd3, 4'h5, 10, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_job(10'h3FE, 10'd2, 10'h3FE, 10'd4, 4'h9, 50, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_job(10'h100, 10'd5, 10'h0FE, 10'd9, 4'h3, 8, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_job(10'h000, 10'd0, 10'h000, 10'd0, 4'hC, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_job(10'h200, 10'd4, 10'h200, 10'd4, 4'h7, 6, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_job(10'h050, 10'd2, 10'h04F, 10'd3, 4'hA, 4, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a five-word load, after two words have been written.
    clear_mon();
    w0 = rand_word(); w1 = rand_word();
    issue_start(10'h300, 10'd5, 10'h300, 10'd5, 4'h6);
    push_word(w0, 1'b0);
    push_word(w1, 1'b0);
    ref_mem[10'h300] = w0;
    ref_mem[10'h301] = w1;
    s_valid = 1'b1; s_data = rand_word();
    rstn = 1'b0;
    @(negedge clk);
    check("rstmid_wr", DW'(core_extin_en), '0);
    tick();
    check("rstmid_idle", DW'(idle), DW'(1));
    check("rstmid_sready", DW'(s_ready), '0);
    rstn = 1'b1; s_valid = 1'b0;
    repeat (4) tick();
    check("rstmid_run", DW'(run_cnt), '0);
    check("rstmid_wcnt", DW'(wr_addr_q.size()), DW'(2));
    $display("job reset-mid-load writes=%0d runs=%0d idle=%0b", wr_addr_q.size(), run_cnt, idle);
    do_job(10'h300, 10'd3, 10'h300, 10'd5, 4'h6, 12, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < 8; j++)
      do_job(AW'($urandom), AW'($urandom_range(0, 6)), AW'($urandom), AW'($urandom_range(0, 9)),
             4'($urandom), $urandom_range(1, 20), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             1'b0, 1'b0, 1'b0);

`ifdef PAIRING_HOST_WDOG_EN
    begin
      int t = 0;
      clear_mon();
      force_busy = 1'b1;
      issue_start(10'h000, 10'd0, 10'h010, 10'd4, 4'h2);
      m_ready = 1'b1;
      while (done_cnt == 0 && t < 400) begin tick(); t++; end
      tick();
      force_busy = 1'b0; m_ready = 1'b0;
      $display("job watchdog done=%0d err=%0b outs=%0d", done_cnt, err, out_q.size());
      check("wdog_done", DW'(done_cnt), DW'(1));
      check("wdog_err", DW'(err), DW'(1));
      check("wdog_lat", DW'(done_cyc - run_cyc), DW'(101));
      check("wdog_out", DW'(out_q.size()), '0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pairing_host_ctrl.md
Name: pairing_host_ctrl

Overview:
Host-side controller for the pairing core's external memory port. It streams operand words from a valid/ready source into core BRAM through the extin write port and issues a one-cycle run with a function code. It then waits for the core to go idle and streams result words back out through the extout read port, which has a 2-cycle read latency. The block sits between the system interconnect/DMA and the pairing core.

Parameters:
DATA_W, 304, width of one redundant L3 memory word (extin_data/extout_data)
ADDR_W, 10, core external address width (BRAM_DEPTH+1)
RD_LAT, 2, core extout read latency in cycles
FIFO_D, 4, result skid FIFO depth (power of 2, >= RD_LAT+1)
WDOG_CYC, 24'hFFFFFF, watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  begin job; sampled only in IDLE
n_func  in  4  function code passed to the core
ld_base  in  ADDR_W  first load address
ld_len  in  ADDR_W  number of words to load (0 = skip load)
rd_base  in  ADDR_W  first result address
rd_len  in  ADDR_W  number of words to unload (0 = skip unload)
s_valid  in  1  operand word valid
s_ready  out  1  operand word accepted
s_data  in  DATA_W  operand word
m_valid  out  1  result word valid
m_ready  in  1  downstream accepts result
m_data  out  DATA_W  result word
m_last  out  1  marks final result word
core_extin_en  out  1  core write enable
core_extin_addr  out  ADDR_W  core write address
core_extin_data  out  DATA_W  core write data
core_run  out  1  one-cycle run pulse
core_n_func  out  4  function code to core
core_busy  in  1  core busy
core_extout_addr  out  ADDR_W  core read address
core_extout_data  in  DATA_W  core read data
done  out  1  one-cycle pulse at job completion
err  out  1  sticky error flag; cleared by next accepted start
idle  out  1  high in IDLE

Behaviour:
- Reset is rstn, synchronous, active-low; the clock is clk. On reset: state=IDLE; all outputs 0 except idle=1; FIFO and counters are cleared. Reset asserted mid-job aborts the job immediately, and no further core writes or run pulses are issued.
- States: IDLE, LOAD, RUN, WAIT_HI, WAIT_LO, UNLOAD, DONE.
- IDLE: start=1 latches n_func, the bases and the lengths, and clears err. The next state is LOAD if ld_len!=0, otherwise RUN. start in any other state is ignored.
- LOAD: s_ready=1 only in this state. Each s_valid&s_ready transfer drives core_extin_en=1, core_extin_addr=ld_base+i and core_extin_data=s_data in that same cycle (combinational passthrough, registered at the core). Addresses wrap modulo 2^ADDR_W. After the ld_len-th transfer, go to RUN.
- RUN: core_run=1 for exactly one cycle, with core_n_func held stable from IDLE through DONE. Then go to WAIT_HI.
- WAIT_HI: wait for core_busy=1, then go to WAIT_LO. WAIT_LO: wait for core_busy=0, then go to UNLOAD, or to DONE if rd_len=0.
- UNLOAD: core_extout_addr=rd_base+k, wrapping modulo 2^ADDR_W. An address is issued only if in_flight+fifo_count < FIFO_D. A per-cycle issue shift register of depth RD_LAT tags returning data, which is pushed into the FIFO exactly RD_LAT cycles after issue.
  - Issue rate with no backpressure is 1 word/cycle.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last=1 on the rd_len-th output word.
  - Go to DONE when that word completes a handshake.
- Backpressure: m_ready=0 never drops data. Issue stalls once credits are exhausted.
- DONE: done=1 for one cycle, then IDLE.
- core_extout_addr holds its last value outside UNLOAD. core_extin_en=0 outside LOAD.
- Core writes occur only while core_busy=0. If core_busy=1 is seen in LOAD, set err=1, drop the write and keep waiting; s_ready=0 while core_busy=1.

Optional Feature:
Macro PAIRING_HOST_WDOG_EN.
- Defined: a 24-bit counter runs in WAIT_HI and WAIT_LO. When it reaches WDOG_CYC, the block sets err=1, skips UNLOAD and goes to DONE (done still pulses).
- Undefined: no counter; the wait states wait indefinitely.

Test Plan:
- Load ld_base=0x010, ld_len=3, words A,B,C with no stalls -> extin writes at 0x010/0x011/0x012 in 3 consecutive cycles; a run pulse follows one cycle after the last write, with core_n_func equal to the latched value.
- Core model busy for 50 cycles with rd_base=0x3FE, rd_len=4 -> reads at 0x3FE, 0x3FF, 0x000, 0x001 (wrap); 4 m_valid words in order; m_last on the 4th; one done pulse.
- m_ready toggled 1/0 per cycle and then held 0 for 20 cycles during unload -> no word lost or duplicated; outstanding reads never exceed FIFO_D=4.
- ld_len=0 and rd_len=0 -> IDLE→RUN→WAIT_HI→WAIT_LO→DONE; no extin_en, no read issue, done pulses once.
- rstn=0 asserted mid-LOAD after 2 of 5 words -> the next cycle has idle=1, s_ready=0, no run pulse; a new start behaves normally.
- With PAIRING_HOST_WDOG_EN and WDOG_CYC=100, core busy stuck at 1 -> err=1 and a done pulse after 100 wait cycles; no m_valid.
